// File: rtl/rand_range_sampler.sv
// rand_range_sampler: mask-and-reject sampler that turns a raw LFSR byte stream
// into unbiased values in [0, limit], buffered in a DEPTH-entry FIFO.
//
// Ports:
//   clk        rising-edge clock (LFSR domain)
//   reset      asynchronous active-low reset
//   random     raw LFSR byte, new every cycle
//   en         sampling enable
//   limit      inclusive upper bound of the output range
//   out_valid  FIFO head holds a value
//   out_ready  consumer takes the head this cycle
//   out_data   FIFO head value, 0 when empty
//   level      FIFO occupancy
//   state      00 IDLE, 01 SAMPLING, 10 STALLED
//   rejects    saturating count of out-of-range rejections
//   stuck      stuck-source flag
//
// Optional: define RAND_STUCK_DETECT_EN to enable the stuck-source detector;
// otherwise stuck is tied to 0.
module rand_range_sampler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned STUCK_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               random,
  input  logic                     en,
  input  logic [7:0]               limit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               state,
  output logic [7:0]               rejects,
  output logic                     stuck
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (1 << AW) != DEPTH || STUCK_LIMIT < 2) begin : g_bad_cfg
    $error("rand_range_sampler: unsupported DEPTH/STUCK_LIMIT");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SAMPLING = 2'b01,
    STALLED  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      rejects_q;
  logic [7:0]      mask, candidate;
  logic            in_range, has_room, push, pop, reject;
  logic            stuck_q;

  // Smear the highest set bit of limit downward to get the smallest 2^k-1 >= limit.
  always_comb begin
    mask = limit;
    mask = mask | (mask >> 1);
    mask = mask | (mask >> 2);
    mask = mask | (mask >> 4);
  end

  assign candidate = random & mask;
  assign in_range  = (candidate <= limit);
  assign has_room  = (level_q != FULL);
  assign push      = en && has_room && in_range && !stuck_q;
  assign reject    = en && has_room && !in_range && !stuck_q;
  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = SAMPLING;
        SAMPLING: state_d = (level_d == FULL) ? STALLED : SAMPLING;
        STALLED:  state_d = (level_d != FULL) ? SAMPLING : STALLED;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      state_q   <= IDLE;
      rejects_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_d;
      state_q <= state_d;
      if (reject && rejects_q != '1) rejects_q <= rejects_q + 1'b1;
    end
  end

  // Storage needs no reset: occupancy gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= candidate;
  end

`ifdef RAND_STUCK_DETECT_EN
  localparam int unsigned CW = $clog2(STUCK_LIMIT) + 1;
  localparam logic [CW-1:0] RUN_MAX = CW'(STUCK_LIMIT - 1);

  logic [7:0]    prev;
  logic [CW-1:0] run_cnt;
  logic          same_byte;

  assign same_byte = (random == prev);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev    <= '0;
      run_cnt <= '0;
      stuck_q <= 1'b0;
    end else begin
      prev <= random;
      if (same_byte) begin
        if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
        if (run_cnt == RUN_MAX - 1'b1) stuck_q <= 1'b1;
      end else begin
        run_cnt <= '0;
      end
    end
  end
`else
  assign stuck_q = 1'b0;
`endif

  assign out_data = out_valid ? mem[rd_ptr] : '0;
  assign level    = level_q;
  assign state    = state_q;
  assign rejects  = rejects_q;
  assign stuck    = stuck_q;

endmodule

// File: tb/tb_rand_range_sampler.sv
module tb_rand_range_sampler;

  logic       clk;
  logic       reset;
  logic [7:0] random;
  logic       en;
  logic [7:0] limit;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] level;
  logic [1:0] state;
  logic [7:0] rejects;
  logic       stuck;

  int unsigned checks = 0;
  int unsigned errors = 0;

  rand_range_sampler #(
    .DEPTH       (4),
    .STUCK_LIMIT (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .random    (random),
    .en        (en),
    .limit     (limit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .state     (state),
    .rejects   (rejects),
    .stuck     (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_head;
    logic       exp_stuck;
    logic [2:0] exp_level;

    reset = 1'b0; en = 1'b0; random = 8'h00; limit = 8'h00; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_data", 32'(out_data), 32'd0);
    check("idle_level", 32'(level), 32'd0);
    check("idle_state", 32'(state), 32'd0);
    check("idle_rejects", 32'(rejects), 32'd0);
    check("idle_stuck", 32'(stuck), 32'd0);

    // Range accept / reject with limit=5 (mask 7).
    limit = 8'd5; en = 1'b1; random = 8'h0B;
    tick();
    check("acc_level", 32'(level), 32'd1);
    check("acc_data", 32'(out_data), 32'd3);
    check("acc_valid", 32'(out_valid), 32'd1);
    check("acc_state", 32'(state), 32'd1);
    random = 8'h1E;
    tick();
    check("rej_level", 32'(level), 32'd1);
    check("rej_rejects", 32'(rejects), 32'd1);
    check("rej_data", 32'(out_data), 32'd3);
    en = 1'b0; out_ready = 1'b1;
    tick();
    check("drain_level", 32'(level), 32'd0);
    check("drain_data", 32'(out_data), 32'd0);
    check("drain_state", 32'(state), 32'd0);
    out_ready = 1'b0;

    // Fill to full, then a dropped sample that is not counted.
    limit = 8'hFF; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      random = 8'h10 + 8'(i);
      tick();
    end
    check("full_level", 32'(level), 32'd4);
    check("full_state", 32'(state), 32'd2);
    random = 8'h14;
    tick();
    check("drop_level", 32'(level), 32'd4);
    check("drop_rejects", 32'(rejects), 32'd1);
    check("drop_state", 32'(state), 32'd2);
    en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_head = 8'h10 + 8'(i);
      check("pop_order", 32'(out_data), 32'(exp_head));
      tick();
    end
    check("pop_valid", 32'(out_valid), 32'd0);
    check("pop_state", 32'(state), 32'd0);
    tick();
    check("empty_pop_level", 32'(level), 32'd0);

    // Simultaneous push/pop across pointer wrap.
    out_ready = 1'b0; en = 1'b1;
    random = 8'h20; tick();
    random = 8'h21; tick();
    check("sim_pre_level", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      random   = 8'h22 + 8'(i);
      exp_head = 8'h20 + 8'(i);
      check("sim_head", 32'(out_data), 32'(exp_head));
      tick();
      check("sim_level", 32'(level), 32'd2);
    end
    en = 1'b0;
    check("sim_tail0", 32'(out_data), 32'h24);
    tick();
    check("sim_tail1", 32'(out_data), 32'h25);
    tick();
    check("sim_empty", 32'(level), 32'd0);
    out_ready = 1'b0;

    // limit=0: every byte maps to 0 and is accepted.
    limit = 8'd0; en = 1'b1; random = 8'hFF;
    tick();
    check("lim0_level", 32'(level), 32'd1);
    check("lim0_data", 32'(out_data), 32'd0);
    check("lim0_valid", 32'(out_valid), 32'd1);
    check("lim0_rejects", 32'(rejects), 32'd1);
    random = 8'hA5; tick();
    random = 8'h3C; tick();
    check("lim0_level3", 32'(level), 32'd3);

    // Asynchronous reset mid-stream.
    reset = 1'b0;
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_rejects", 32'(rejects), 32'd0);

    // Constant all-zero source.
    random = 8'h00; en = 1'b1; limit = 8'hFF; out_ready = 1'b1;
    tick();
    reset = 1'b1;
    repeat (16) tick();
    random = 8'h55;
    repeat (2) tick();
    out_ready = 1'b0;
    repeat (2) tick();
`ifdef RAND_STUCK_DETECT_EN
    exp_stuck = 1'b1; exp_level = 3'd0;
`else
    exp_stuck = 1'b0; exp_level = 3'd3;
`endif
    check("stuck_flag", 32'(stuck), 32'(exp_stuck));
    check("stuck_level", 32'(level), 32'(exp_level));

    // Reject counter saturation with limit=128 (mask 0xFF).
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("sat_start", 32'(rejects), 32'd0);
    limit = 8'd128; en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 255; i++) begin
      random = (i % 2 == 0) ? 8'hC0 : 8'hC1;
      tick();
    end
    check("sat_255", 32'(rejects), 32'd255);
    for (int i = 0; i < 10; i++) begin
      random = (i % 2 == 0) ? 8'hC0 : 8'hC1;
      tick();
    end
    check("sat_hold", 32'(rejects), 32'd255);
    check("sat_level", 32'(level), 32'd0);
    random = 8'h80;
    tick();
    check("lim128_level", 32'(level), 32'd1);
    check("lim128_data", 32'(out_data), 32'h80);
    en = 1'b0; random = 8'h81;
    tick();
    check("en0_rejects", 32'(rejects), 32'd255);
    check("en0_level", 32'(level), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_range_sampler.md
Name: rand_range_sampler

Overview:
- Downstream consumer of the free-running 8-bit LFSR byte stream.
- Turns raw pseudo-random bytes into unbiased values in [0, limit] by mask-and-reject sampling.
- Buffers accepted values in a small FIFO behind a valid/ready handshake for game/test logic.
- Sits between the LFSR output bus and any client that needs bounded random numbers.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- STUCK_LIMIT, 16: consecutive identical input bytes that flag a stuck source. Only used with the optional feature.

Ports:
- clk  input  1  rising-edge clock, same domain as the LFSR.
- reset  input  1  asynchronous, active-low reset. 0 = reset asserted.
- random  input  8  raw LFSR byte; new value every cycle.
- en  input  1  sampling enable.
- limit  input  8  inclusive upper bound of the output range.
- out_valid  output  1  head of FIFO holds a valid value.
- out_ready  input  1  consumer accepts the head this cycle.
- out_data  output  8  head value; 0 when out_valid=0.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- state  output  2  00 IDLE, 01 SAMPLING, 10 STALLED.
- rejects  output  8  saturating count of out-of-range rejections.
- stuck  output  1  stuck-source flag; tied 0 when the feature is compiled out.

Behaviour:
- Reset (reset=0, async): FIFO pointers=0, level=0, out_valid=0, out_data=0, state=IDLE, rejects=0, stuck=0. Release is synchronous to the next clk edge; first sample is taken on the first edge after release.
- mask = smallest (2^k - 1) >= limit, computed combinationally. limit=0 gives mask=0; limit=255 gives mask=0xFF.
- candidate = random & mask. Sample is in range iff candidate <= limit.
- Push condition: en=1 AND level<DEPTH AND candidate in range AND stuck=0. There is no pass-through when full, even if a pop happens in the same cycle.
- Reject: en=1, level<DEPTH, candidate out of range. rejects increments and saturates at 255. Samples dropped because of full, en=0 or stuck are not counted.
- Pop: out_valid & out_ready. Advances the read pointer. out_ready while empty is ignored.
- Simultaneous push and pop: level unchanged; pointers both advance, wrapping modulo DEPTH.
- Latency: a byte accepted at edge N is visible on out_data/out_valid after edge N when the FIFO was empty (registered output, 1 cycle).
- Ordering: strict FIFO order. A change of limit affects only future samples; entries already buffered are kept.
- out_data is driven from the head storage entry and is forced to 0 when level=0.
- FSM, evaluated each edge:
  - IDLE -> SAMPLING when en=1.
  - SAMPLING -> STALLED when the next level = DEPTH.
  - STALLED -> SAMPLING when the next level < DEPTH.
  - Any state -> IDLE when en=0; the FIFO keeps draining in IDLE.
- Reset asserted mid-operation: FIFO contents are discarded immediately and all outputs return to reset values asynchronously.

Optional Feature:
- Macro: RAND_STUCK_DETECT_EN.
- Defined:
  - Register the previous byte. Run_cnt increments while random equals the previous byte and clears on a change.
  - When run_cnt reaches STUCK_LIMIT-1 repeats, stuck=1. stuck is sticky until reset.
  - While stuck=1, all pushes are blocked; the FIFO still drains.
  - Catches an all-zero or lock-up LFSR.
- Undefined: no comparison logic; stuck is tied 0 and pushes are never blocked by it.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release with en=0 -> out_valid=0, out_data=0, level=0, state=00, rejects=0.
- Range accept: limit=5 (mask 7), en=1, random=0x0B then 0x1E, out_ready=0 -> 0x0B&7=3 is accepted; 0x1E&7=6 is rejected. Result: level=1, out_data=3, rejects=1.
- Fill/stall: limit=255, en=1, random 0x10,0x11,0x12,0x13,0x14, out_ready=0 -> level=4, state=10. The 0x14 sample is dropped and rejects stays 0. Then pop 4 with out_ready=1 -> 0x10..0x13 in order, out_valid=0.
- Simultaneous push/pop: with level=2, drive a valid byte and out_ready=1 on the same cycle -> level stays 2 and ordering is preserved across pointer wrap.
- limit=0: random 0xFF -> accepted value 0, no rejects. Assert reset mid-stream with level=3 -> level=0 and out_valid=0 immediately.
- With RAND_STUCK_DETECT_EN, STUCK_LIMIT=16: hold random=0x00 for 16 cycles -> stuck=1 and no further pushes. Change random -> stuck stays 1 until reset.
